// File: rtl/scoreboard_pkg.sv
// Shared types, constants and BCD helpers for the scoreboard display rotator.
package scoreboard_pkg;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef logic [1:0] mode_t;
  localparam mode_t MODE_ROTATE = 2'b00;
  localparam mode_t MODE_HOLD   = 2'b01;
  localparam mode_t MODE_LEADER = 2'b10;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_e;

  // Mode 2'b11 behaves exactly like rotate.
  function automatic mode_t norm_mode(input logic [1:0] m);
    return (m == 2'b11) ? MODE_ROTATE : m;
  endfunction

  // Numeric weight of a digit; invalid BCD counts as zero.
  function automatic logic [3:0] bcd_digit(input logic [3:0] n);
    return (n > 4'd9) ? 4'd0 : n;
  endfunction

  // Display code of a digit; invalid BCD is shown as the blank code.
  function automatic logic [3:0] bcd_disp(input logic [3:0] n);
    return (n > 4'd9) ? BCD_BLANK : n;
  endfunction

  function automatic logic [6:0] bcd_value(input logic [7:0] b);
    return (7'(bcd_digit(b[7:4])) * 7'd10) + 7'(bcd_digit(b[3:0]));
  endfunction

endpackage

// File: rtl/scoreboard_display_rotator_leader.sv
// score_leader_find: combinational arg-max over BCD scores, ties to the
// lowest index, invalid nibbles weighted as zero.
module score_leader_find
  import scoreboard_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_PLAYERS*8-1:0] scores_i,
  output logic [IDX_W-1:0]         leader_o
);

  logic [6:0] best_val;
  logic [6:0] cur_val;

  // Strict greater-than keeps the earliest player on ties.
  always_comb begin
    leader_o = '0;
    best_val = bcd_value(scores_i[7:0]);
    cur_val  = '0;
    for (int k = 1; k < NUM_PLAYERS; k++) begin
      cur_val = bcd_value(scores_i[k*8 +: 8]);
      if (cur_val > best_val) begin
        best_val = cur_val;
        leader_o = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/scoreboard_display_rotator.sv
// Scoreboard display rotator: drives one tens/ones digit pair from
// NUM_PLAYERS BCD scores in rotate, hold or leader mode.
// Optional build macro LEADING_ZERO_BLANK_EN blanks a leading tens zero.
//
// state    | meaning
// ST_SHOW  | digits show player idx; counter runs the dwell time
// ST_BLANK | digits blanked between players; counter runs the gap time
module scoreboard_display_rotator
  import scoreboard_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int DWELL_MS    = 2000,
  parameter int BLANK_MS    = 200,
  parameter int IDX_W       = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                     clk_1khz,
  input  logic                     rst_ni,
  input  logic [NUM_PLAYERS*8-1:0] scores_i,
  input  logic [1:0]               mode_i,
  input  logic [IDX_W-1:0]         sel_i,
  output logic [3:0]               tens_o,
  output logic [3:0]               ones_o,
  output logic [IDX_W-1:0]         player_o,
  output logic                     blank_o
);

  localparam int CNT_TOP = (DWELL_MS > BLANK_MS) ? DWELL_MS : BLANK_MS;
  localparam int CNT_W   = (CNT_TOP > 0) ? $clog2(CNT_TOP + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CNT_TOP);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DWELL_TC = CNT_W'(DWELL_MS);
  localparam logic [CNT_W-1:0] BLANK_TC = CNT_W'(BLANK_MS);
  localparam int NSLOT = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLAYERS - 1);

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [NUM_PLAYERS*8-1:0] hist_q;
  mode_t                    mode_q, mode_cur;
  logic [3:0]               tens_q, tens_d, ones_q, ones_d;
  logic [IDX_W-1:0]         player_q, player_d;
  logic                     blank_q, blank_d;

  logic [7:0]       score_a [NSLOT];
  logic [7:0]       disp;
  logic [IDX_W-1:0] show_idx, leader_idx, jump_idx, next_idx;
  logic             show_blank, jump_vld;

  // Pad the score array to a power of two so any index width is in range.
  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    if (g < NUM_PLAYERS) begin : g_used
      assign score_a[g] = scores_i[g*8 +: 8];
    end else begin : g_pad
      assign score_a[g] = 8'h00;
    end
  end

  score_leader_find #(
    .NUM_PLAYERS (NUM_PLAYERS),
    .IDX_W       (IDX_W)
  ) u_leader (
    .scores_i (scores_i),
    .leader_o (leader_idx)
  );

  // Lowest-index player whose byte moved since the previous cycle.
  always_comb begin
    jump_vld = 1'b0;
    jump_idx = '0;
    for (int k = NUM_PLAYERS - 1; k >= 0; k--) begin
      if (scores_i[k*8 +: 8] != hist_q[k*8 +: 8]) begin
        jump_vld = 1'b1;
        jump_idx = IDX_W'(k);
      end
    end
  end

  // Next state, counter and displayed channel for all three modes.
  always_comb begin
    mode_cur   = norm_mode(mode_i);
    cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    next_idx   = (idx_q >= LAST_IDX) ? '0 : idx_q + 1'b1;
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_inc;
    show_idx   = idx_q;
    show_blank = 1'b0;
    if (mode_cur == MODE_ROTATE) begin
      if (jump_vld) begin
        state_d = ST_SHOW;
        idx_d   = jump_idx;
        cnt_d   = '0;
      end else if (mode_q != MODE_ROTATE) begin
        // Resume from whoever was on screen; an out-of-range hold
        // selection restarts at player 0.
        state_d = ST_SHOW;
        idx_d   = (player_q > LAST_IDX) ? '0 : player_q;
        cnt_d   = '0;
      end else if (state_q == ST_SHOW) begin
        if (cnt_q >= DWELL_TC) begin
          cnt_d = CNT_ONE;
          if (BLANK_MS > 0) begin
            state_d = ST_BLANK;
          end else begin
            idx_d = next_idx;
          end
        end
      end else if (cnt_q >= BLANK_TC) begin
        state_d = ST_SHOW;
        idx_d   = next_idx;
        cnt_d   = CNT_ONE;
      end
      show_idx   = idx_d;
      show_blank = (state_d == ST_BLANK);
    end else begin
      state_d = ST_SHOW;
      cnt_d   = '0;
      if (mode_cur == MODE_HOLD) begin
        show_idx   = sel_i;
        show_blank = (sel_i > LAST_IDX);
      end else begin
        show_idx = leader_idx;
      end
    end
  end

  // Digit decode of the channel chosen above.
  always_comb begin
    disp   = score_a[show_idx];
    tens_d = bcd_disp(disp[7:4]);
    ones_d = bcd_disp(disp[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
    if (disp[7:4] == 4'd0) begin
      tens_d = BCD_BLANK;
    end
`endif
    if (show_blank) begin
      tens_d = BCD_BLANK;
      ones_d = BCD_BLANK;
    end
    player_d = show_idx;
    blank_d  = show_blank;
  end

  // State, history and registered outputs with synchronous reset.
  always_ff @(posedge clk_1khz) begin
    if (!rst_ni) begin
      state_q  <= ST_SHOW;
      idx_q    <= '0;
      cnt_q    <= '0;
      hist_q   <= scores_i;
      mode_q   <= norm_mode(mode_i);
      tens_q   <= BCD_BLANK;
      ones_q   <= BCD_BLANK;
      player_q <= '0;
      blank_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      hist_q   <= scores_i;
      mode_q   <= mode_cur;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
      player_q <= player_d;
      blank_q  <= blank_d;
    end
  end

  assign tens_o   = tens_q;
  assign ones_o   = ones_q;
  assign player_o = player_q;
  assign blank_o  = blank_q;

endmodule
